// File: rtl/merge_ctrl_if.sv
// Output stream of the merge sequencer: one element per valid/ready handshake.
interface merge_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/merge_ctrl.sv
// Sequencer for the dual index-memory merge datapath: loads both RAMs in lockstep,
// then merges the two sorted lists into one ascending stream.
module merge_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_load,
  input  logic          start_merge,
  input  logic          ld_valid,
  input  logic          ld_last,
  input  logic [AW:0]   len1,
  input  logic [AW:0]   len2,
  input  logic [DW-1:0] r1,
  input  logic [DW-1:0] r2,
  output logic [AW-1:0] cnt1,
  output logic [AW-1:0] cnt2,
  output logic          wr_en,
  output logic          busy,
  output logic          done,
  merge_ctrl_if.master  out_if
);

  localparam logic [AW:0]   DepthLen = (AW + 1)'(2 ** AW);
  localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

  typedef enum logic [2:0] {StIdle, StLoad, StFetch, StMerge, StOut, StFin} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [AW:0]   p1_q, p1_d, p2_q, p2_d;
  logic [AW:0]   len1_q, len1_d, len2_q, len2_d;
  logic [AW+1:0] emit_q, emit_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic          has1, has2, take1;
  logic [AW+1:0] total;
  logic [AW:0]   len1_clamp, len2_clamp;

  // A pointer at DEPTH means that list is exhausted; park its address on the last entry.
  function automatic logic [AW-1:0] sat_addr(input logic [AW:0] p);
    return p[AW] ? LastAddr : p[AW-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    len1_d      = len1_q;
    len2_d      = len2_q;
    emit_d      = emit_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wr_en       = 1'b0;

    len1_clamp = (len1 > DepthLen) ? DepthLen : len1;
    len2_clamp = (len2 > DepthLen) ? DepthLen : len2;
    has1       = p1_q < len1_q;
    has2       = p2_q < len2_q;
    take1      = has1 && (!has2 || (r1 <= r2));
    total      = {1'b0, len1_q} + {1'b0, len2_q};

    unique case (state_q)
      StIdle: begin
        if (start_load) begin
          state_d = StLoad;
          cnt1_d  = '0;
          cnt2_d  = '0;
        end else if (start_merge) begin
          len1_d  = len1_clamp;
          len2_d  = len2_clamp;
          p1_d    = '0;
          p2_d    = '0;
          cnt1_d  = '0;
          cnt2_d  = '0;
          emit_d  = '0;
          state_d = (len1_clamp == '0 && len2_clamp == '0) ? StFin : StFetch;
        end
      end
      StLoad: begin
        wr_en = ld_valid;
        if (ld_valid) begin
          if (cnt1_q == LastAddr) begin
            state_d = StFin;
          end else begin
            cnt1_d = cnt1_q + 1'b1;
            cnt2_d = cnt2_q + 1'b1;
          end
          if (ld_last) state_d = StFin;
        end
      end
      StFetch: state_d = StMerge;
      StMerge: begin
        out_valid_d = 1'b1;
        emit_d      = emit_q + 1'b1;
        state_d     = StOut;
        if (take1) begin
          out_data_d = r1;
          p1_d       = p1_q + 1'b1;
          cnt1_d     = sat_addr(p1_q + 1'b1);
        end else begin
          out_data_d = r2;
          p2_d       = p2_q + 1'b1;
          cnt2_d     = sat_addr(p2_q + 1'b1);
        end
      end
      StOut: begin
        if (out_if.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (emit_q == total) ? StFin : StFetch;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      len1_q      <= '0;
      len2_q      <= '0;
      emit_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      len1_q      <= len1_d;
      len2_q      <= len2_d;
      emit_q      <= emit_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign cnt1             = cnt1_q;
  assign cnt2             = cnt2_q;
  assign busy             = (state_q != StIdle);
  assign done             = (state_q == StFin);
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule
